mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between three requesters: UART/debug loader (LD),
//  MEM-stage data port (DM) and IFetch (IF). Serialises accesses with a 4-state FSM, returns
//  registered read data and one-cycle done pulses, and drives the pipeline stall from pending requests.
//  Sits between IFetch/MEM and the shared RAM; replaces the separate per-stage memories.
// PARAMETERS
//  ADDR_W  14  word address width
//  DATA_W  32  data width
//  RD_LAT  1   memory read latency in cycles (legal 1..3); mem_rdata valid RD_LAT cycles after mem_en
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  ld_req     in   1       loader request, held until ld_done
//  ld_we      in   1       loader write enable
//  ld_addr    in   ADDR_W  loader address
//  ld_wdata   in   DATA_W  loader write data
//  ld_done    out  1       loader access complete (1-cycle pulse)
//  dm_req/dm_we/dm_addr/dm_wdata   in   1/1/ADDR_W/DATA_W   data port request, same rules as LD
//  dm_rdata   out  DATA_W  data read result, valid with dm_done, held until next DM read
//  dm_done    out  1       data access complete pulse
//  if_req     in   1       fetch request (read only)
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetched instruction, valid with if_done, held until next IF read
//  if_done    out  1       fetch complete pulse
//  stall      out  1       (if_req & ~if_done) | (dm_req & ~dm_done); combinational, to pipeline stall
//  mem_en, mem_we  out 1   memory strobe / write, asserted only in ISSUE
//  mem_addr   out  ADDR_W  memory address (registered with grant)
//  mem_wdata  out  DATA_W  memory write data (registered with grant)
//  mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, owner=NONE, cnt=0, all done=0, mem_en=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, dm_rdata=0, if_rdata=0, last_dm=0. Access in flight is abandoned.
//  States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE: arbitrate only here. Priority LD > DM > IF, except when last_dm=1 and if_req=1: IF wins
//    over DM (no DM back-to-back while IF waits). LD always wins. On grant latch owner, we, addr,
//    wdata; go ISSUE. No req: stay IDLE.
//   ISSUE: exactly one cycle mem_en=1, mem_we=owner we (IF: 0). Write -> DONE. Read -> WAIT, cnt=1.
//   WAIT: if cnt==RD_LAT capture mem_rdata into owner rdata reg, go DONE; else cnt++.
//   DONE: owner done=1 for this cycle only; last_dm <= (owner==DM); go IDLE. No arbitration in DONE.
//  Latency, req seen in IDLE cycle T: write done in T+2; read done in T+2+RD_LAT (T+3 for RD_LAT=1).
//  Requester rules: hold req/addr/wdata stable until done; may change addr at the done edge and keep
//   req high for the next access (sampled in following IDLE). Req dropped mid-access: access still
//   completes, done still pulses, rdata still updated.
//  Loader rdata: LD reads return data on dm_rdata (shared read register); dm_done is NOT pulsed.
//  Address/data are registered at grant; input changes after grant have no effect.
//  Simultaneous LD+DM+IF in IDLE: LD granted; DM/IF keep stall high until served.
//  RD_LAT outside 1..3: elaboration error.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE/ISSUE/WAIT/DONE), owner enum (NONE/LD/DM/IF),
//   RD_LAT bounds constants. One combinational sub-module mem_arb_pick (reqs + last_dm -> owner);
//   FSM, counter and result registers live in mem_port_arbiter.
// TESTING
//  1 IF read only, RD_LAT=1, mem[0x10]=0x00500093, if_req@T -> mem_en@T+1, if_done@T+3, if_rdata=0x00500093, stall low@T+3.
//  2 DM write addr 0x20 data 0xDEADBEEF -> mem_we=1 @T+1 only, dm_done@T+2, then DM read 0x20 -> dm_rdata=0xDEADBEEF.
//  3 DM+IF held high continuously -> grants alternate DM,IF,DM,IF; never two DM grants while if_req=1.
//  4 LD+DM+IF all asserted @T -> LD served first, stall stays 1 until both DM and IF done.
//  5 rst pulse during WAIT (RD_LAT=3) -> immediate IDLE, mem_en=0, no done pulse, rdata=0; next req served normally.
//  6 RD_LAT=3 read, if_req dropped @ISSUE -> if_done still pulses @T+5, if_rdata updated; mem_en exactly 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter.
// FSM states, grant owners and legal read-latency range.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LD,
    OWN_DM,
    OWN_IF
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, result and memory-side signals of the arbiter.
// master = requesters plus RAM, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_done;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output if_req, if_addr,
    output mem_rdata,
    input  ld_done, dm_done, dm_rdata,
    input  if_done, if_rdata, stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  if_req, if_addr,
    input  mem_rdata,
    output ld_done, dm_done, dm_rdata,
    output if_done, if_rdata, stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Grant selection: LD first, then DM, except IF
// beats DM right after a DM access.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   ld_req_i,
  input  logic   dm_req_i,
  input  logic   if_req_i,
  input  logic   last_dm_i,
  output owner_e owner_o
);

  logic dm_yield;

  assign dm_yield = if_req_i & last_dm_i;

  always_comb begin
    owner_o = OWN_NONE;
    unique case (1'b1)
      ld_req_i:
        owner_o = OWN_LD;
      (~ld_req_i & dm_req_i & ~dm_yield):
        owner_o = OWN_DM;
      (~ld_req_i & if_req_i &
       (~dm_req_i | last_dm_i)):
        owner_o = OWN_IF;
      default:
        owner_o = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises LD/DM/IF onto one RAM port with a
// four-state FSM; registered results and done pulses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX)
  begin : g_bad_lat
    $error("RD_LAT must be within 1..3");
  end

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            pick;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_dm_q, last_dm_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              issue, done;
  logic              dm_done, if_done;

  mem_arb_pick u_pick (
    .ld_req_i  (bus.ld_req),
    .dm_req_i  (bus.dm_req),
    .if_req_i  (bus.if_req),
    .last_dm_i (last_dm_q),
    .owner_o   (pick)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    last_dm_d  = last_dm_q;
    dm_rdata_d = dm_rdata_q;
    if_rdata_d = if_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        owner_d = pick;
        if (pick != OWN_NONE) state_d = ST_ISSUE;
        unique case (pick)
          OWN_LD: begin
            we_d    = bus.ld_we;
            addr_d  = bus.ld_addr;
            wdata_d = bus.ld_wdata;
          end
          OWN_DM: begin
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
          end
          OWN_IF: begin
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            wdata_d = '0;
          end
          default: ;
        endcase
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 2'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT) begin
          state_d = ST_DONE;
          cnt_d   = 2'd0;
          // Loader reads share the data-port result register
          if (owner_q == OWN_IF)
            if_rdata_d = bus.mem_rdata;
          else
            dm_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        last_dm_d = (owner_q == OWN_DM);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 2'd0;
      last_dm_q  <= 1'b0;
      dm_rdata_q <= '0;
      if_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      last_dm_q  <= last_dm_d;
      dm_rdata_q <= dm_rdata_d;
      if_rdata_q <= if_rdata_d;
    end
  end

  assign issue = (state_q == ST_ISSUE);
  assign done  = (state_q == ST_DONE);

  assign dm_done = done & (owner_q == OWN_DM);
  assign if_done = done & (owner_q == OWN_IF);

  assign bus.ld_done   = done & (owner_q == OWN_LD);
  assign bus.dm_done   = dm_done;
  assign bus.if_done   = if_done;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.stall = (bus.if_req & ~if_done) |
                     (bus.dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus random
// traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'h0050_0093;
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // RAM environment with a LAT-deep read pipe
  logic [31:0] ram [256];
  logic [31:0] pipe [LAT];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    pipe[0] <= (bus.mem_en && !bus.mem_we) ?
               ram[bus.mem_addr[7:0]] : 32'hBADC_0DE0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.mem_rdata = pipe[LAT-1];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] refm [256];
  int          t;
  bit          busy;
  int          cur;
  int          g, d;
  bit          cur_we;
  logic [13:0] e_addr;
  logic [31:0] e_wdata, rd_val, e_dm, e_if;
  bit          last_dm;

  bit seen_ld, seen_dm, seen_if, seen_stall;
  int en_cnt;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    busy = 0; cur = 0; last_dm = 0;
    e_addr = '0; e_wdata = '0; e_dm = '0; e_if = '0;
  endtask

  task automatic grant();
    int who;
    who = 0;
    if (bus.ld_req) who = 1;
    else if (bus.dm_req && !(bus.if_req && last_dm)) who = 2;
    else if (bus.if_req) who = 3;
    if (who != 0) begin
      busy = 1; cur = who; g = t;
      case (who)
        1: begin
          cur_we = bus.ld_we; e_addr = bus.ld_addr;
          e_wdata = bus.ld_wdata;
        end
        2: begin
          cur_we = bus.dm_we; e_addr = bus.dm_addr;
          e_wdata = bus.dm_wdata;
        end
        default: begin
          cur_we = 0; e_addr = bus.if_addr; e_wdata = '0;
        end
      endcase
      d = t + (cur_we ? 2 : 2 + LAT);
      if (cur_we) refm[e_addr[7:0]] = e_wdata;
      else rd_val = refm[e_addr[7:0]];
    end
  endtask

  task automatic tick();
    bit iss, dn, eld, edm, eif;
    @(negedge clk);
    iss = busy && (t == g + 1);
    dn  = busy && (t == d);
    if (dn && !cur_we) begin
      if (cur == 3) e_if = rd_val;
      else e_dm = rd_val;
    end
    eld = dn && cur == 1;
    edm = dn && cur == 2;
    eif = dn && cur == 3;
    check("mem_en", bus.mem_en, iss);
    check("mem_we", bus.mem_we, iss && cur_we);
    check("mem_addr", bus.mem_addr, e_addr);
    if (iss && cur_we)
      check("mem_wdata", bus.mem_wdata, e_wdata);
    check("ld_done", bus.ld_done, eld);
    check("dm_done", bus.dm_done, edm);
    check("if_done", bus.if_done, eif);
    check("dm_rdata", bus.dm_rdata, e_dm);
    check("if_rdata", bus.if_rdata, e_if);
    check("stall", bus.stall,
          (bus.if_req && !eif) || (bus.dm_req && !edm));
    seen_ld = bus.ld_done;
    seen_dm = bus.dm_done;
    seen_if = bus.if_done;
    seen_stall = bus.stall;
    if (bus.mem_en) en_cnt++;
    if (busy) begin
      if (dn) begin
        busy = 0;
        last_dm = (cur == 2);
      end
    end else begin
      grant();
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(int who, output int tdone);
    bit hit;
    tdone = -1;
    for (int n = 0; n < 60; n++) begin
      tick();
      hit = (who == 1) ? seen_ld :
            (who == 2) ? seen_dm : seen_if;
      if (hit) begin
        tdone = t - 1;
        break;
      end
    end
    if (tdone < 0) check("timeout", 0, 1);
  endtask

  task automatic rnd_drive(int who);
    bit          req, dn, nw;
    logic [13:0] a;
    logic [31:0] w;
    req = (who == 1) ? bus.ld_req :
          (who == 2) ? bus.dm_req : bus.if_req;
    dn  = (who == 1) ? seen_ld :
          (who == 2) ? seen_dm : seen_if;
    nw  = 0;
    if (req && dn) begin
      if ($urandom_range(1) == 1) req = 0;
      else nw = 1;
    end else if (req) begin
      if ($urandom_range(99) < 2) req = 0;
    end else if ($urandom_range(99) < 12) begin
      req = 1; nw = 1;
    end
    a = 14'($urandom_range(0, 31));
    w = $urandom;
    case (who)
      1: begin
        bus.ld_req = req;
        if (nw) begin
          bus.ld_addr = a; bus.ld_wdata = w;
          bus.ld_we = 1'($urandom_range(1));
        end
      end
      2: begin
        bus.dm_req = req;
        if (nw) begin
          bus.dm_addr = a; bus.dm_wdata = w;
          bus.dm_we = 1'($urandom_range(1));
        end
      end
      default: begin
        bus.if_req = req;
        if (nw) bus.if_addr = a;
      end
    endcase
  endtask

  initial begin
    int tt, td, prev, o, k, first, en0;
    bit got_dm, got_if;

    rst = 1; preload = 1; t = 0; en_cnt = 0;
    bus.ld_req = 0; bus.ld_we = 0;
    bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.if_req = 0; bus.if_addr = '0;
    for (int i = 0; i < 256; i++) refm[i] = init_word(i);
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_dones",
          {bus.ld_done, bus.dm_done, bus.if_done}, 0);
    check("rst_rdata", {bus.dm_rdata, bus.if_rdata}, 0);
    check("rst_stall", bus.stall, 0);
    @(posedge clk); #1;
    rst = 0; preload = 0;

    // plain fetch
    bus.if_req = 1; bus.if_addr = 14'h10;
    tt = t;
    wait_for(3, td);
    check("t1_lat", td - tt, 2 + LAT);
    check("t1_data", bus.if_rdata, 32'h0050_0093);
    check("t1_stall", seen_stall, 0);
    bus.if_req = 0;

    // data write then read back
    bus.dm_req = 1; bus.dm_we = 1;
    bus.dm_addr = 14'h20; bus.dm_wdata = 32'hDEAD_BEEF;
    tt = t;
    wait_for(2, td);
    check("t2_wlat", td - tt, 2);
    bus.dm_we = 0;
    tt = t;
    wait_for(2, td);
    check("t2_rlat", td - tt, 2 + LAT);
    check("t2_data", bus.dm_rdata, 32'hDEAD_BEEF);
    bus.dm_req = 0;

    // DM and IF contending: grants must alternate
    bus.dm_req = 1; bus.dm_addr = 14'h3;
    bus.if_req = 1; bus.if_addr = 14'h4;
    prev = 0; k = 0;
    for (int n = 0; n < 120 && k < 6; n++) begin
      tick();
      if (seen_dm || seen_if) begin
        o = seen_dm ? 2 : 3;
        if (prev != 0) check("t3_alt", o, prev == 2 ? 3 : 2);
        prev = o; k++;
        if (seen_dm) bus.dm_addr = 14'($urandom_range(0, 31));
        else bus.if_addr = 14'($urandom_range(0, 31));
      end
    end
    check("t3_count", k, 6);
    bus.dm_req = 0; bus.if_req = 0;
    tick();

    // all three at once: loader first
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 14'h5;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 14'h6;
    bus.dm_wdata = 32'h1234_5678;
    bus.if_req = 1; bus.if_addr = 14'h7;
    first = 0; got_dm = 0; got_if = 0;
    for (int n = 0; n < 100 && !(got_dm && got_if); n++) begin
      tick();
      if (first == 0) begin
        if (seen_ld) first = 1;
        else if (seen_dm) first = 2;
        else if (seen_if) first = 3;
      end
      if (seen_ld) bus.ld_req = 0;
      if (seen_dm) begin got_dm = 1; bus.dm_req = 0; end
      if (seen_if) begin got_if = 1; bus.if_req = 0; end
    end
    check("t4_first", first, 1);
    check("t4_dm_if", {got_dm, got_if}, 2'b11);

    // reset in the middle of a read wait
    bus.if_req = 1; bus.if_addr = 14'h10;
    repeat (3) tick();
    rst = 1;
    #2;
    check("t5_mem_en", bus.mem_en, 0);
    check("t5_done", bus.if_done, 0);
    check("t5_if_rdata", bus.if_rdata, 0);
    check("t5_dm_rdata", bus.dm_rdata, 0);
    check("t5_mem_addr", bus.mem_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    tt = t;
    wait_for(3, td);
    check("t5_lat", td - tt, 2 + LAT);
    check("t5_data", bus.if_rdata, 32'h0050_0093);
    bus.if_req = 0;

    // fetch request dropped right after grant
    bus.if_req = 1; bus.if_addr = 14'h33;
    en0 = en_cnt;
    tt = t;
    tick();
    bus.if_req = 0;
    wait_for(3, td);
    check("t6_lat", td - tt, 2 + LAT);
    check("t6_en", en_cnt - en0, 1);
    check("t6_data", bus.if_rdata, init_word(8'h33));

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      rnd_drive(1);
      rnd_drive(2);
      rnd_drive(3);
    end
    bus.ld_req = 0; bus.dm_req = 0; bus.if_req = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
